// File: rtl/hwpe_ctrl_job_sched_pkg.sv
// Shared types for the HWPE job scheduler: FSM state encoding and a width helper.
package hwpe_ctrl_job_sched_pkg;

    typedef enum logic [1:0] {
        JS_IDLE  = 2'd0,
        JS_DELAY = 2'd1,
        JS_RUN   = 2'd2
    } job_sched_state_t;

    // Index width that never collapses to zero bits for 1- or 2-entry ranges.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/hwpe_ctrl_job_sched_if.sv
// Control bundle between slave decode, job scheduler and engine FSM.
// Signal suffixes are from the scheduler's point of view.
interface hwpe_ctrl_job_sched_if #(
    parameter int N_CORES      = 8,
    parameter int N_CONTEXT    = 3,
    parameter int N_EVT        = 4,
    parameter int JOB_ID_WIDTH = 8
);
    import hwpe_ctrl_job_sched_pkg::*;

    localparam int CORE_W = clog2_min1(N_CORES);
    localparam int CTX_W  = clog2_min1(N_CONTEXT);
    localparam int NP_W   = $clog2(N_CONTEXT + 1);

    logic                              clear_i;
    logic                              acquire_i;
    logic                              acquire_ok_o;
    logic [CTX_W-1:0]                  acquire_ctx_o;
    logic [JOB_ID_WIDTH-1:0]           acquire_job_id_o;
    logic                              commit_i;
    logic [CORE_W-1:0]                 commit_core_i;
    logic                              done_i;
    logic [N_EVT-2:0]                  evt_i;
    logic                              start_o;
    logic                              busy_o;
    logic [CTX_W-1:0]                  running_ctx_o;
    logic [JOB_ID_WIDTH-1:0]           running_job_id_o;
    logic [NP_W-1:0]                   n_pending_o;
    logic                              full_o;
    logic                              err_o;
    logic [N_CORES-1:0][N_EVT-1:0]     evt_o;

    modport slave (
        input  clear_i, acquire_i, commit_i, commit_core_i, done_i, evt_i,
        output acquire_ok_o, acquire_ctx_o, acquire_job_id_o, start_o, busy_o,
               running_ctx_o, running_job_id_o, n_pending_o, full_o, err_o, evt_o
    );

    modport master (
        output clear_i, acquire_i, commit_i, commit_core_i, done_i, evt_i,
        input  acquire_ok_o, acquire_ctx_o, acquire_job_id_o, start_o, busy_o,
               running_ctx_o, running_job_id_o, n_pending_o, full_o, err_o, evt_o
    );

endinterface

// File: rtl/hwpe_ctrl_ctx_ring.sv
// Purpose: circular store of committed job slots {core, job_id} with any-size wrap.
// Latency: push/pop take effect at the next edge; read side is combinational from rd_ptr.
// Backpressure: none; the caller only pushes into free space and pops a live head.
module hwpe_ctrl_ctx_ring
    import hwpe_ctrl_job_sched_pkg::*;
#(
    parameter int  N_CORES      = 8,
    parameter int  N_CONTEXT    = 3,
    parameter int  JOB_ID_WIDTH = 8,
    localparam int CORE_W       = clog2_min1(N_CORES),
    localparam int CTX_W        = clog2_min1(N_CONTEXT),
    localparam int NP_W         = $clog2(N_CONTEXT + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    push_i,
    input  logic [CORE_W-1:0]       push_core_i,
    input  logic [JOB_ID_WIDTH-1:0] push_job_id_i,
    input  logic                    pop_i,
    output logic [CTX_W-1:0]        wr_ptr_o,
    output logic [CTX_W-1:0]        rd_ptr_o,
    output logic [CORE_W-1:0]       rd_core_o,
    output logic [JOB_ID_WIDTH-1:0] rd_job_id_o,
    output logic [NP_W-1:0]         n_pending_o
);
    typedef struct packed {
        logic [CORE_W-1:0]       core;
        logic [JOB_ID_WIDTH-1:0] job_id;
    } job_slot_t;

    job_slot_t         slot_q [N_CONTEXT];
    logic [CTX_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [NP_W-1:0]   n_pending_q;

    // Explicit wrap at N_CONTEXT-1 so non-power-of-two depths behave.
    function automatic logic [CTX_W-1:0] ptr_inc(input logic [CTX_W-1:0] p);
        return (p == CTX_W'(N_CONTEXT - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_CONTEXT; i++) slot_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            n_pending_q <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < N_CONTEXT; i++) slot_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            n_pending_q <= '0;
        end else begin
            if (push_i) begin
                slot_q[wr_ptr_q] <= '{core: push_core_i, job_id: push_job_id_i};
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push_i, pop_i})
                2'b10:   n_pending_q <= n_pending_q + 1'b1;
                2'b01:   n_pending_q <= n_pending_q - 1'b1;
                default: n_pending_q <= n_pending_q;
            endcase
        end
    end

    assign wr_ptr_o    = wr_ptr_q;
    assign rd_ptr_o    = rd_ptr_q;
    assign rd_core_o   = slot_q[rd_ptr_q].core;
    assign rd_job_id_o = slot_q[rd_ptr_q].job_id;
    assign n_pending_o = n_pending_q;

endmodule

// File: rtl/hwpe_ctrl_job_sched.sv
// Purpose: multi-context HWPE job scheduler (acquire -> commit -> start -> done, per-core events).
// Latency: start_o START_DELAY+2 cycles after a commit into an idle queue; events one cycle after input.
// Backpressure: acquire_ok_o gates reservations; done_i outside RUN is dropped.
module hwpe_ctrl_job_sched
    import hwpe_ctrl_job_sched_pkg::*;
#(
    parameter int N_CORES      = 8,
    parameter int N_CONTEXT    = 3,
    parameter int N_EVT        = 4,
    parameter int START_DELAY  = 1,
    parameter int JOB_ID_WIDTH = 8
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    hwpe_ctrl_job_sched_if.slave ctrl
);
    localparam int CORE_W = clog2_min1(N_CORES);
    localparam int CTX_W  = clog2_min1(N_CONTEXT);
    localparam int NP_W   = $clog2(N_CONTEXT + 1);
    localparam int DLY_W  = clog2_min1(START_DELAY);

    job_sched_state_t          state_q, state_d;
    logic [DLY_W-1:0]          dly_cnt_q, dly_cnt_d;
    logic                      start_q, start_d;
    logic                      reserved_q, reserved_d;
    logic [JOB_ID_WIDTH-1:0]   job_id_q, job_id_d;
    logic                      err_q, err_d;
    logic [N_CORES-1:0][N_EVT-1:0] evt_q, evt_d;

    logic                      run, busy, acquire_ok, push, pop;
    logic [CTX_W-1:0]          wr_ptr, rd_ptr;
    logic [CORE_W-1:0]         rd_core;
    logic [JOB_ID_WIDTH-1:0]   rd_job_id;
    logic [NP_W-1:0]           n_pending;

    assign acquire_ok = !reserved_q && (n_pending < NP_W'(N_CONTEXT));
    assign push       = ctrl.commit_i && reserved_q;
    assign pop        = run && ctrl.done_i;

    hwpe_ctrl_ctx_ring #(
        .N_CORES      (N_CORES),
        .N_CONTEXT    (N_CONTEXT),
        .JOB_ID_WIDTH (JOB_ID_WIDTH)
    ) i_ring (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .clear_i       (ctrl.clear_i),
        .push_i        (push),
        .push_core_i   (ctrl.commit_core_i),
        .push_job_id_i (job_id_q),
        .pop_i         (pop),
        .wr_ptr_o      (wr_ptr),
        .rd_ptr_o      (rd_ptr),
        .rd_core_o     (rd_core),
        .rd_job_id_o   (rd_job_id),
        .n_pending_o   (n_pending)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= JS_IDLE;
            dly_cnt_q <= '0;
            start_q   <= 1'b0;
        end else if (ctrl.clear_i) begin
            state_q   <= JS_IDLE;
            dly_cnt_q <= '0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            dly_cnt_q <= dly_cnt_d;
            start_q   <= start_d;
        end
    end

    // start_d marks the DELAY->RUN hop so start_o lands on the first RUN cycle.
    always_comb begin
        state_d   = state_q;
        dly_cnt_d = dly_cnt_q;
        start_d   = 1'b0;
        unique case (state_q)
            JS_IDLE: begin
                if (n_pending != '0) begin
                    state_d   = JS_DELAY;
                    dly_cnt_d = '0;
                end
            end
            JS_DELAY: begin
                if (dly_cnt_q == DLY_W'(START_DELAY - 1)) begin
                    state_d = JS_RUN;
                    start_d = 1'b1;
                end else begin
                    dly_cnt_d = dly_cnt_q + 1'b1;
                end
            end
            JS_RUN: begin
                if (ctrl.done_i) state_d = JS_IDLE;
            end
            default: state_d = JS_IDLE;
        endcase
    end

    always_comb begin
        run  = (state_q == JS_RUN);
        busy = (state_q != JS_IDLE);
    end

    always_comb begin
        reserved_d = reserved_q;
        job_id_d   = job_id_q;
        err_d      = err_q;
        evt_d      = '0;
        if (ctrl.commit_i) begin
            if (reserved_q) begin
                reserved_d = 1'b0;
                job_id_d   = job_id_q + 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (ctrl.acquire_i && acquire_ok) reserved_d = 1'b1;
        if (run) begin
            evt_d[rd_core][N_EVT-1:1] = ctrl.evt_i;
            evt_d[rd_core][0]         = ctrl.done_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reserved_q <= 1'b0;
            job_id_q   <= '0;
            err_q      <= 1'b0;
            evt_q      <= '0;
        end else if (ctrl.clear_i) begin
            reserved_q <= 1'b0;
            job_id_q   <= '0;
            err_q      <= 1'b0;
            evt_q      <= '0;
        end else begin
            reserved_q <= reserved_d;
            job_id_q   <= job_id_d;
            err_q      <= err_d;
            evt_q      <= evt_d;
        end
    end

    assign ctrl.acquire_ok_o     = acquire_ok;
    assign ctrl.acquire_ctx_o    = wr_ptr;
    assign ctrl.acquire_job_id_o = job_id_q;
    assign ctrl.start_o          = start_q;
    assign ctrl.busy_o           = busy;
    assign ctrl.running_ctx_o    = rd_ptr;
    assign ctrl.running_job_id_o = rd_job_id;
    assign ctrl.n_pending_o      = n_pending;
    assign ctrl.full_o           = (n_pending == NP_W'(N_CONTEXT));
    assign ctrl.err_o            = err_q;
    assign ctrl.evt_o            = evt_q;

endmodule

// File: tb/tb_hwpe_ctrl_job_sched.sv
// Randomized + directed bench for hwpe_ctrl_job_sched against a timestamp-based job queue model.
module tb_hwpe_ctrl_job_sched;
    localparam int NCO = 8, NCX = 3, NEV = 4, SD = 1, JW = 2;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hwpe_ctrl_job_sched_if #(.N_CORES(NCO), .N_CONTEXT(NCX), .N_EVT(NEV), .JOB_ID_WIDTH(JW)) bus ();

    hwpe_ctrl_job_sched #(
        .N_CORES(NCO), .N_CONTEXT(NCX), .N_EVT(NEV), .START_DELAY(SD), .JOB_ID_WIDTH(JW)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .ctrl   (bus)
    );

    int n_vec = 0, n_err = 0, cyc = 0;

    // Model: queue of committed jobs with commit cycle; start time derived from when engine frees up.
    typedef struct {int core; int id; int cc;} job_t;
    job_t q[$];
    int   ms_id [NCX];
    int   wr, rd, nid, free_c;
    bit   res, merr;
    logic [NCO-1:0][NEV-1:0] evt_cur;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NCX; i++) ms_id[i] = 0;
        wr = 0; rd = 0; nid = 0; res = 0; merr = 0;
        evt_cur = '0;
        free_c = cyc;
    endtask

    function automatic int head_start();
        int v;
        v = (free_c > q[0].cc + 1) ? free_c : q[0].cc + 1;
        return v + SD + 1;
    endfunction

    task automatic check();
        logic eb, es;
        eb = 1'b0; es = 1'b0;
        if (q.size() > 0) begin
            eb = (cyc >= head_start() - SD);
            es = (cyc == head_start());
        end
        chk("acquire_ok", bus.acquire_ok_o, (!res && q.size() < NCX));
        chk("acquire_ctx", bus.acquire_ctx_o, wr);
        chk("acquire_job_id", bus.acquire_job_id_o, nid);
        chk("start", bus.start_o, es);
        chk("busy", bus.busy_o, eb);
        chk("running_ctx", bus.running_ctx_o, rd);
        chk("running_job_id", bus.running_job_id_o, ms_id[rd]);
        chk("n_pending", bus.n_pending_o, q.size());
        chk("full", bus.full_o, (q.size() == NCX));
        chk("err", bus.err_o, merr);
        chk("evt", bus.evt_o, evt_cur);
    endtask

    task automatic model_step(input bit clr, input bit acq, input bit cmt, input int core,
                              input bit done, input logic [NEV-2:0] evt);
        bit ok, run;
        int hc;
        ok  = !res && q.size() < NCX;
        run = 0; hc = 0;
        if (q.size() > 0) begin
            run = (cyc >= head_start());
            hc  = q[0].core;
        end
        if (clr) begin
            model_reset();
            free_c = cyc + 1;
            return;
        end
        evt_cur = '0;
        if (run) begin
            evt_cur[hc][NEV-1:1] = evt;
            evt_cur[hc][0]       = done;
        end
        if (done && run) begin
            void'(q.pop_front());
            rd = (rd + 1) % NCX;
            free_c = cyc + 1;
        end
        if (cmt) begin
            if (res) begin
                job_t j;
                j.core = core; j.id = nid; j.cc = cyc;
                q.push_back(j);
                ms_id[wr] = nid;
                wr  = (wr + 1) % NCX;
                nid = (nid + 1) % (1 << JW);
                res = 0;
            end else begin
                merr = 1;
            end
        end
        if (acq && ok) res = 1;
    endtask

    task automatic zero_in();
        bus.clear_i = 0; bus.acquire_i = 0; bus.commit_i = 0;
        bus.commit_core_i = '0; bus.done_i = 0; bus.evt_i = '0;
    endtask

    task automatic go(input bit clr, input bit acq, input bit cmt, input int core,
                      input bit done, input logic [NEV-2:0] evt);
        bus.clear_i = clr; bus.acquire_i = acq; bus.commit_i = cmt;
        bus.commit_core_i = core[CW-1:0]; bus.done_i = done; bus.evt_i = evt;
        @(negedge clk);
        check();
        model_step(clr, acq, cmt, core, done, evt);
        @(posedge clk); #1;
        cyc++;
        zero_in();
    endtask

    task automatic idle();
        go(0, 0, 0, 0, 0, '0);
    endtask

    task automatic do_reset();
        zero_in();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        check();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++;
        free_c = cyc;
    endtask

    task automatic wait_start(output int at);
        at = -1;
        for (int k = 0; k < 12; k++) begin
            if (bus.start_o === 1'b1) begin
                at = cyc;
                break;
            end
            idle();
        end
        if (at < 0) chk("start_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout cyc=%0d got=running want=finished", cyc);
        $fatal(1);
    end

    initial begin
        int at, c0, core;
        int t6_ids [5];
        t6_ids = '{0, 1, 2, 3, 0};
        zero_in();
        #2;

        // Single job on core 5
        do_reset();
        chk("t1_ok", bus.acquire_ok_o, 1);
        chk("t1_ctx", bus.acquire_ctx_o, 0);
        chk("t1_id", bus.acquire_job_id_o, 0);
        go(0, 1, 0, 0, 0, '0);
        c0 = cyc;
        go(0, 0, 1, 5, 0, '0);
        wait_start(at);
        chk("t1_start_lat", at - c0, 3);
        go(0, 0, 0, 0, 1, '0);
        chk("t1_evt5", bus.evt_o, 64'd1 << (5 * NEV));
        idle();
        chk("t1_evt_clr", bus.evt_o, 0);

        // Fill all contexts, reject 4th acquire, drain in order
        do_reset();
        for (int i = 0; i < 3; i++) begin
            go(0, 1, 0, 0, 0, '0);
            go(0, 0, 1, i + 1, 0, '0);
        end
        chk("t2_full", bus.full_o, 1);
        chk("t2_ok", bus.acquire_ok_o, 0);
        go(0, 1, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) wait_start(at);
            chk("t2_ctx", bus.running_ctx_o, i);
            go(0, 0, 0, 0, 1, '0);
            if (i == 0) chk("t2_ok_after", bus.acquire_ok_o, 1);
        end
        chk("t2_wrap", bus.acquire_ctx_o, 0);
        chk("t2_np0", bus.n_pending_o, 0);

        // Commit without reservation, double acquire
        do_reset();
        go(0, 0, 1, 2, 0, '0);
        chk("t3_err", bus.err_o, 1);
        chk("t3_np", bus.n_pending_o, 0);
        go(0, 1, 0, 0, 0, '0);
        chk("t3_ok2", bus.acquire_ok_o, 0);
        go(0, 1, 0, 0, 0, '0);
        go(0, 0, 1, 2, 0, '0);
        chk("t3_np1", bus.n_pending_o, 1);
        chk("t3_err_sticky", bus.err_o, 1);

        // Commit concurrent with done
        do_reset();
        go(0, 1, 0, 0, 0, '0); go(0, 0, 1, 2, 0, '0);
        go(0, 1, 0, 0, 0, '0); go(0, 0, 1, 3, 0, '0);
        wait_start(at);
        go(0, 1, 0, 0, 0, '0);
        go(0, 0, 1, 4, 1, '0);
        chk("t4_np", bus.n_pending_o, 2);
        wait_start(at);
        chk("t4_ctx", bus.running_ctx_o, 1);
        chk("t4_id", bus.running_job_id_o, 1);

        // Clear mid-run
        do_reset();
        go(0, 1, 0, 0, 0, '0); go(0, 0, 1, 6, 0, '0);
        go(0, 1, 0, 0, 0, '0); go(0, 0, 1, 7, 0, '0);
        wait_start(at);
        go(0, 0, 0, 0, 0, 3'b101);
        go(1, 0, 0, 0, 0, '0);
        chk("t5_busy", bus.busy_o, 0);
        chk("t5_np", bus.n_pending_o, 0);
        chk("t5_evt", bus.evt_o, 0);
        go(0, 0, 0, 0, 1, '0);
        chk("t5_late_done", bus.evt_o, 0);

        // Job ID wrap and per-core events
        do_reset();
        for (int i = 0; i < 5; i++) begin
            core = (i * 3 + 1) % NCO;
            go(0, 1, 0, 0, 0, '0);
            go(0, 0, 1, core, 0, '0);
            wait_start(at);
            chk("t6_id", bus.running_job_id_o, t6_ids[i]);
            go(0, 0, 0, 0, 1, '0);
            chk("t6_evt", bus.evt_o, 64'd1 << (core * NEV));
        end

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            go($urandom_range(0, 199) < 2,
               $urandom_range(0, 1) == 1,
               res ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 2),
               int'($urandom_range(0, NCO - 1)),
               $urandom_range(0, 99) < 30,
               3'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
